// File: rtl/check_dispatcher_pkg.sv
// Shared types for the check dispatcher: metadata word layout, FSM state
// encoding and channel-1 stream widths.
package check_dispatcher_pkg;

    localparam int DATA_W  = 512;
    localparam int EMPTY_W = 6;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [15:0] flow_id;
        logic [7:0]  rule_set;
        logic [7:0]  flags;
    } metadata_t;

    typedef enum logic {
        IDLE = 1'b0,
        FWD  = 1'b1
    } disp_state_e;

    // Index width for an engine count; a 1-bit index is kept for tiny configs.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/check_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting engine
// searching upward from last_grant+1, wrapping at N-1.
module rr_arbiter
    import check_dispatcher_pkg::*;
#(
    parameter int N  = 4,
    parameter int LW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic          any_grant
);

    logic [LW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        // i runs 1..N so last_grant itself is considered last.
        for (int i = 1; i <= N; i++) begin
            idx = LW'((int'(last_grant) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_grant = |req;

endmodule

// File: rtl/check_dispatcher.sv
// Routes each channel-1 packet plus its metadata word to one of NUM_ENG
// rule-check engines, chosen round-robin among engines not almost full.
module check_dispatcher
    import check_dispatcher_pkg::*;
#(
    parameter int NUM_ENG = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              in_pkt_data,
    input  logic                           in_pkt_valid,
    input  logic                           in_pkt_sop,
    input  logic                           in_pkt_eop,
    input  logic [EMPTY_W-1:0]             in_pkt_empty,
    output logic                           in_pkt_ready,
    input  metadata_t                      in_meta_data,
    input  logic                           in_meta_valid,
    output logic                           in_meta_ready,
    input  logic [NUM_ENG-1:0]             eng_almost_full,
    output logic [DATA_W-1:0]              out_pkt_data,
    output logic                           out_pkt_sop,
    output logic                           out_pkt_eop,
    output logic [EMPTY_W-1:0]             out_pkt_empty,
    output logic [NUM_ENG-1:0]             out_pkt_valid,
    output metadata_t                      out_meta_data,
    output logic [NUM_ENG-1:0]             out_meta_valid,
    output logic [NUM_ENG-1:0][CNT_W-1:0]  eng_pkt_cnt
);

    localparam int LW = idx_width(NUM_ENG);

    disp_state_e        state, state_nxt;
    logic [LW-1:0]      grant_idx;
    logic [LW-1:0]      last_grant;
    logic [NUM_ENG-1:0] arb_grant;
    logic               arb_any;
    logic [LW-1:0]      arb_idx;
    logic [NUM_ENG-1:0] grant_oh;
    logic               pkt_fire;
    logic               eop_fire;
    logic               start_pkt;

    rr_arbiter #(
        .N  (NUM_ENG),
        .LW (LW)
    ) u_arb (
        .req        (~eng_almost_full),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any_grant  (arb_any)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (arb_grant[i]) begin
                arb_idx = LW'(i);
            end
        end
    end

    assign grant_oh  = NUM_ENG'(1) << grant_idx;
    assign start_pkt = (state == IDLE) && in_meta_valid && arb_any;
    assign pkt_fire  = (state == FWD) && in_pkt_valid;
    assign eop_fire  = pkt_fire && in_pkt_eop;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_pkt) state_nxt = FWD;
            FWD:     if (eop_fire)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs; metadata is consumed together with the eop flit.
    always_comb begin
        in_pkt_ready  = 1'b0;
        in_meta_ready = 1'b0;
        if (state == FWD) begin
            in_pkt_ready  = 1'b1;
            in_meta_ready = in_pkt_valid && in_pkt_eop;
        end
    end

    // Grant is frozen for the whole packet; almost_full is only sampled in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_idx  <= LW'(NUM_ENG - 1);
            last_grant <= LW'(NUM_ENG - 1);
        end else begin
            if (start_pkt) begin
                grant_idx <= arb_idx;
            end
            if (eop_fire) begin
                last_grant <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_pkt_valid  <= '0;
            out_meta_valid <= '0;
            eng_pkt_cnt    <= '0;
        end else begin
            out_pkt_valid  <= pkt_fire ? grant_oh : '0;
            out_meta_valid <= eop_fire ? grant_oh : '0;
            if (eop_fire) begin
                eng_pkt_cnt[grant_idx] <= eng_pkt_cnt[grant_idx] + CNT_W'(1);
            end
        end
    end

    // Payload registers free-run; consumers qualify them with the strobes.
    always_ff @(posedge clk) begin
        out_pkt_data  <= in_pkt_data;
        out_pkt_sop   <= in_pkt_sop;
        out_pkt_eop   <= in_pkt_eop;
        out_pkt_empty <= in_pkt_empty;
        out_meta_data <= in_meta_data;
    end

endmodule

// File: tb/tb_check_dispatcher.sv
// Directed bench for check_dispatcher with NUM_ENG=4.
module tb_check_dispatcher;
    import check_dispatcher_pkg::*;

    localparam int NE = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [DATA_W-1:0]         in_pkt_data;
    logic                      in_pkt_valid;
    logic                      in_pkt_sop;
    logic                      in_pkt_eop;
    logic [EMPTY_W-1:0]        in_pkt_empty;
    logic                      in_pkt_ready;
    metadata_t                 in_meta_data;
    logic                      in_meta_valid;
    logic                      in_meta_ready;
    logic [NE-1:0]             eng_almost_full;
    logic [DATA_W-1:0]         out_pkt_data;
    logic                      out_pkt_sop;
    logic                      out_pkt_eop;
    logic [EMPTY_W-1:0]        out_pkt_empty;
    logic [NE-1:0]             out_pkt_valid;
    metadata_t                 out_meta_data;
    logic [NE-1:0]             out_meta_valid;
    logic [NE-1:0][CNT_W-1:0]  eng_pkt_cnt;

    int n_checks = 0;
    int n_err    = 0;
    int exp_cnt [NE];

    check_dispatcher #(.NUM_ENG(NE)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_pkt_data     (in_pkt_data),
        .in_pkt_valid    (in_pkt_valid),
        .in_pkt_sop      (in_pkt_sop),
        .in_pkt_eop      (in_pkt_eop),
        .in_pkt_empty    (in_pkt_empty),
        .in_pkt_ready    (in_pkt_ready),
        .in_meta_data    (in_meta_data),
        .in_meta_valid   (in_meta_valid),
        .in_meta_ready   (in_meta_ready),
        .eng_almost_full (eng_almost_full),
        .out_pkt_data    (out_pkt_data),
        .out_pkt_sop     (out_pkt_sop),
        .out_pkt_eop     (out_pkt_eop),
        .out_pkt_empty   (out_pkt_empty),
        .out_pkt_valid   (out_pkt_valid),
        .out_meta_data   (out_meta_data),
        .out_meta_valid  (out_meta_valid),
        .eng_pkt_cnt     (eng_pkt_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NE-1:0] oh(input int e);
        logic [NE-1:0] v;
        v = '0;
        v[e] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One packet of n flits; gap = flit index preceded by an idle cycle (-1 none).
    // af_mid is applied from flit 1 onward to show the grant does not move.
    task automatic send_pkt(input int n, input int gap, input int eng,
                            input logic [NE-1:0] af_idle, input logic [NE-1:0] af_mid);
        metadata_t   m;
        logic [63:0] w;
        m               = metadata_t'($urandom);
        eng_almost_full = af_idle;
        in_meta_data    = m;
        in_meta_valid   = 1'b1;
        in_pkt_valid    = 1'b0;
        in_pkt_sop      = 1'b0;
        in_pkt_eop      = 1'b0;
        #1;
        chk("idle_pkt_ready", 64'(in_pkt_ready), 64'd0);
        chk("idle_meta_ready", 64'(in_meta_ready), 64'd0);
        tick();
        chk("idle_no_strobe", 64'(out_pkt_valid), 64'd0);
        for (int f = 0; f < n; f++) begin
            if (f == gap) begin
                in_pkt_valid = 1'b0;
                tick();
                chk("bubble_pkt_valid", 64'(out_pkt_valid), 64'd0);
                chk("bubble_meta_valid", 64'(out_meta_valid), 64'd0);
            end
            if (f == 1) eng_almost_full = af_mid;
            w            = {$urandom, $urandom};
            in_pkt_data  = {8{w}};
            in_pkt_valid = 1'b1;
            in_pkt_sop   = (f == 0);
            in_pkt_eop   = (f == n - 1);
            in_pkt_empty = (f == n - 1) ? 6'd5 : 6'd0;
            #1;
            chk("fwd_pkt_ready", 64'(in_pkt_ready), 64'd1);
            chk("fwd_meta_ready", 64'(in_meta_ready), 64'((f == n - 1) ? 1 : 0));
            tick();
            chk("out_pkt_valid", 64'(out_pkt_valid), 64'(oh(eng)));
            chk("out_meta_valid", 64'(out_meta_valid), 64'((f == n - 1) ? oh(eng) : 4'd0));
            chk("out_pkt_data", out_pkt_data[63:0], w);
            chk("out_pkt_sop", 64'(out_pkt_sop), 64'((f == 0) ? 1 : 0));
            chk("out_pkt_eop", 64'(out_pkt_eop), 64'((f == n - 1) ? 1 : 0));
            if (f == n - 1) begin
                chk("out_meta_data", 64'(out_meta_data), 64'(m));
                chk("out_pkt_empty", 64'(out_pkt_empty), 64'd5);
            end
        end
        in_pkt_valid    = 1'b0;
        in_pkt_sop      = 1'b0;
        in_pkt_eop      = 1'b0;
        in_meta_valid   = 1'b0;
        eng_almost_full = '0;
        exp_cnt[eng]++;
        chk("eng_pkt_cnt", 64'(eng_pkt_cnt[eng]), 64'(exp_cnt[eng]));
    endtask

    initial begin
        rst             = 1'b1;
        in_pkt_data     = '0;
        in_pkt_valid    = 1'b0;
        in_pkt_sop      = 1'b0;
        in_pkt_eop      = 1'b0;
        in_pkt_empty    = '0;
        in_meta_data    = '0;
        in_meta_valid   = 1'b0;
        eng_almost_full = '0;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pkt_valid", 64'(out_pkt_valid), 64'd0);
        chk("rst_meta_valid", 64'(out_meta_valid), 64'd0);
        chk("rst_pkt_ready", 64'(in_pkt_ready), 64'd0);
        for (int e = 0; e < NE; e++) chk("rst_cnt", 64'(eng_pkt_cnt[e]), 64'd0);

        // Plain round robin from reset.
        for (int e = 0; e < NE; e++) send_pkt(3, -1, e, 4'b0000, 4'b0000);
        send_pkt(2, -1, 0, 4'b0000, 4'b0000);
        // Engine 1 almost full, last grant 0 -> engine 2.
        send_pkt(3, -1, 2, 4'b0010, 4'b0010);

        // All engines almost full: nothing moves.
        eng_almost_full = 4'b1111;
        in_meta_valid   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("allfull_pkt_ready", 64'(in_pkt_ready), 64'd0);
            chk("allfull_meta_ready", 64'(in_meta_ready), 64'd0);
            tick();
            chk("allfull_strobe", 64'({out_pkt_valid, out_meta_valid}), 64'd0);
        end
        send_pkt(3, -1, 3, 4'b0111, 4'b0111);
        send_pkt(3, -1, 0, 4'b0000, 4'b0000);

        // Single-flit packet, then 5-flit packet with a gap before flit index 2.
        send_pkt(1, -1, 1, 4'b0000, 4'b0000);
        send_pkt(5, 2, 2, 4'b0000, 4'b0000);

        // Reset on flit 2 of a 4-flit packet headed to engine 3.
        in_meta_data  = metadata_t'($urandom);
        in_meta_valid = 1'b1;
        tick();
        in_pkt_data  = {16{$urandom}};
        in_pkt_valid = 1'b1;
        in_pkt_sop   = 1'b1;
        tick();
        chk("prerst_pkt_valid", 64'(out_pkt_valid), 64'(oh(3)));
        in_pkt_sop = 1'b0;
        rst        = 1'b1;
        tick();
        chk("midrst_pkt_valid", 64'(out_pkt_valid), 64'd0);
        chk("midrst_meta_valid", 64'(out_meta_valid), 64'd0);
        for (int e = 0; e < NE; e++) chk("midrst_cnt", 64'(eng_pkt_cnt[e]), 64'd0);
        rst           = 1'b0;
        in_pkt_valid  = 1'b0;
        in_meta_valid = 1'b0;
        foreach (exp_cnt[i]) exp_cnt[i] = 0;
        tick();
        chk("postrst_pkt_valid", 64'(out_pkt_valid), 64'd0);
        send_pkt(2, -1, 0, 4'b0000, 4'b0000);

        // Granted engine goes almost full mid-packet; packet still completes there.
        send_pkt(4, -1, 1, 4'b0000, 4'b0010);
        send_pkt(2, -1, 2, 4'b0000, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/check_dispatcher.md
CHECK_DISPATCHER -- requirements
Module: check_dispatcher

Interface
REQ-001 Parameter: NUM_ENG, default 4, number of downstream rule-check engines fed by channel 1; legal range 2..8.
REQ-002 clk  in  1  clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_pkt_data/in_pkt_valid/in_pkt_sop/in_pkt_eop/in_pkt_empty  in  512/1/1/1/6  channel-1 packet stream.
REQ-005 in_pkt_ready  out  1  packet flit accepted when valid&ready.
REQ-006 in_meta_data/in_meta_valid  in  metadata_t/1  one metadata word per packet.
REQ-007 in_meta_ready  out  1  metadata accepted when valid&ready.
REQ-008 eng_almost_full  in  NUM_ENG  per-engine backpressure; bit i high bars new packets to engine i.
REQ-009 out_pkt_data/out_pkt_sop/out_pkt_eop/out_pkt_empty  out  512/1/1/6  shared registered flit bus to all engines.
REQ-010 out_pkt_valid  out  NUM_ENG  one-hot flit strobe; bit i addresses engine i.
REQ-011 out_meta_data  out  metadata_t  shared registered metadata bus.
REQ-012 out_meta_valid  out  NUM_ENG  one-hot metadata strobe.
REQ-013 eng_pkt_cnt  out  NUM_ENG x 32  packets dispatched per engine.

Function
REQ-014 States: IDLE, FWD.
REQ-015 IDLE->FWD when in_meta_valid and at least one eng_almost_full bit low; grant latched that cycle.
REQ-016 Grant = first engine with almost_full low, searching upward from last_grant+1 modulo NUM_ENG (round-robin, wrap NUM_ENG-1 -> 0).
REQ-017 IDLE: in_pkt_ready=0, in_meta_ready=0.
REQ-018 FWD: in_pkt_ready=1; every accepted flit produces the registered flit and out_pkt_valid=one-hot(grant) exactly 1 cycle later.
REQ-019 FWD: accepted flit with eop -> in_meta_ready=1 in the same cycle; 1 cycle later out_meta_valid=one-hot(grant), concurrent with the eop flit; last_grant<=grant; eng_pkt_cnt[grant]+=1; next state IDLE.
REQ-020 FWD with in_pkt_valid low: bubble; all out_pkt_valid bits 0 next cycle; stay FWD.
REQ-021 Grant holds for the whole packet; eng_almost_full changes mid-packet are ignored (engines size almost_full margin for one max packet).
REQ-022 All engines almost full in IDLE: remain IDLE, no ready, no output strobes.
REQ-023 Single-flit packet (sop&eop): one FWD cycle, metadata and flit emitted together; minimum packet period 2 cycles (IDLE+FWD).
REQ-024 At most one bit of out_pkt_valid and out_meta_valid high per cycle.
REQ-025 eng_pkt_cnt wraps modulo 2^32 without saturation.
REQ-026 Data/sop/eop/empty/meta output registers load every cycle without reset; only strobes are qualified.

Reset
REQ-027 rst -> state IDLE, out_pkt_valid=0, out_meta_valid=0, eng_pkt_cnt=0, last_grant=NUM_ENG-1 (first grant engine 0).
REQ-028 rst mid-packet abandons the packet; no strobes for its remaining flits; upstream flushing is the upstream's responsibility.

Structure
REQ-029 metadata_t comes from the shared struct package; NUM_ENG is a module parameter, not a package constant.
REQ-030 One sub-module, rr_arbiter: combinational, NUM_ENG request mask plus last_grant in, one-hot grant plus any_grant out.

Verification
REQ-031 Four 3-flit packets, no backpressure -> grants engines 0,1,2,3 in order; each eng_pkt_cnt=1.
REQ-032 eng_almost_full=4'b0010 and last_grant=0 -> next packet to engine 2 (engine 1 skipped).
REQ-033 eng_almost_full=4'b1111 with meta valid -> ready stays 0; clear to 4'b0111 -> packet to engine 3; next packet wraps to engine 0.
REQ-034 Single-flit packet then 5-flit packet with in_pkt_valid gap on flit 3 -> meta strobe with flit 1 only; one-cycle strobe bubble, correct engine.
REQ-035 rst asserted on flit 2 of a 4-flit packet -> strobes 0 next cycle, counters 0; next packet goes to engine 0.
REQ-036 Set eng_almost_full[grant] mid-packet -> packet completes to the same engine with no stall.
